rc4_ksa: RTL

Parametrised RC4 key-scheduling engine: optionally fills the 256-byte S-box with the identity permutation, then runs the KSA swap loop over a runtime-selectable key length against an external single-port synchronous RAM of configurable read latency. Sits between the key-search controller (start/done/abort) and the S-box RAM; its output drives the PRGA/decrypt stage that follows.

---
 rtl/rc4_pkg.sv | 34 +++
 rtl/rc4_key_sel.sv | 71 +++++++
 rtl/rc4_ksa.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc4_pkg
// Description : Shared RC4 definitions: engine state encoding, S-box geometry
//               and legal RAM read-latency range. Imported by the KSA engine
//               and by the PRGA stage that follows it.
// Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

    localparam int SBOX_SIZE  = 256;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    // Wide enough to count 0..RD_LAT_MAX.
    localparam int WAIT_W     = 3;

    // The index advance (i++, k step) is folded into the WR_I edge so that a
    // KSA iteration costs 2*(RD_LAT+1)+3 cycles; there is no separate state
    // for it.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FILL   = 4'd1,
        ST_RD_I   = 4'd2,
        ST_CALC_J = 4'd3,
        ST_RD_J   = 4'd4,
        ST_WR_J   = 4'd5,
        ST_WR_I   = 4'd6,
        ST_DONE   = 4'd7
    } rc4_state_e;

endpackage
`default_nettype wire

// File: rtl/rc4_key_sel.sv
`default_nettype none
// ============================================================================
// Module      : rc4_key_sel
// Description : Holds the captured RC4 key and the key-byte index k. k wraps
//               at the clamped key length; key byte 0 is the MSB of key_i.
// Ports       : clk, rst_n     - clock, async active-low reset
//               load_i         - capture key_i/key_len_i, clear k
//               step_i         - advance k (wrapping)
//               key_i          - packed key, byte 0 most significant
//               key_len_i      - active key bytes (0 -> 1, >MAX -> MAX)
//               key_byte_o     - key[k]
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_key_sel
    import rc4_pkg::*;
#(
    parameter  int MAX_KEY_BYTES = 3,
    localparam int LEN_W         = $clog2(MAX_KEY_BYTES + 1),
    localparam int K_W           = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_i,
    input  logic                       step_i,
    input  logic [8*MAX_KEY_BYTES-1:0] key_i,
    input  logic [LEN_W-1:0]           key_len_i,
    output logic [DATA_W-1:0]          key_byte_o
);

    logic [8*MAX_KEY_BYTES-1:0] key_q;
    logic [K_W-1:0]             k_q;
    logic [K_W-1:0]             last_q;
    logic [K_W-1:0]             last_d;
    logic [LEN_W-1:0]           len_eff;
    logic [DATA_W-1:0]          key_bytes [MAX_KEY_BYTES];

    always_comb begin
        len_eff = key_len_i;
        if (key_len_i == '0) begin
            len_eff = LEN_W'(1);
        end else if (key_len_i > LEN_W'(MAX_KEY_BYTES)) begin
            len_eff = LEN_W'(MAX_KEY_BYTES);
        end
        // len_eff is 1..MAX, so len_eff-1 always fits the index width.
        last_d = K_W'(len_eff - LEN_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= '0;
            k_q    <= '0;
            last_q <= '0;
        end else if (load_i) begin
            key_q  <= key_i;
            k_q    <= '0;
            last_q <= last_d;
        end else if (step_i) begin
            k_q    <= (k_q == last_q) ? '0 : k_q + K_W'(1);
        end
    end

    always_comb begin
        for (int b = 0; b < MAX_KEY_BYTES; b++) begin
            key_bytes[b] = key_q[8*(MAX_KEY_BYTES-1-b) +: 8];
        end
    end

    assign key_byte_o = key_bytes[k_q];

endmodule
`default_nettype wire

// File: rtl/rc4_ksa.sv
`default_nettype none
// ============================================================================
// Module      : rc4_ksa
// Description : RC4 key-scheduling engine. Optionally fills the external
//               S-box RAM with the identity permutation, then runs the 256
//               KSA swap iterations against a single-port synchronous RAM
//               with RD_LAT cycles of read latency (legal 1..4).
// Ports       : clk, rst_n     - clock, async active-low reset
//               start_i        - begin run (IDLE only); wins over abort_i
//               abort_i        - synchronous cancel in any busy state
//               init_en_i      - run identity FILL first (sampled with start)
//               key_len_i      - active key bytes (sampled with start)
//               secret_key_i   - key, byte 0 most significant
//               q_i            - RAM read data
//               wen_o/address_o/data_o - RAM write enable, address, data
//               busy_o         - high outside IDLE
//               done_o         - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_ksa
    import rc4_pkg::*;
#(
    parameter  int MAX_KEY_BYTES = 3,
    parameter  int RD_LAT        = 1,
    localparam int LEN_W         = $clog2(MAX_KEY_BYTES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       init_en_i,
    input  logic [LEN_W-1:0]           key_len_i,
    input  logic [8*MAX_KEY_BYTES-1:0] secret_key_i,
    input  logic [DATA_W-1:0]          q_i,
    output logic                       wen_o,
    output logic [ADDR_W-1:0]          address_o,
    output logic [DATA_W-1:0]          data_o,
    output logic                       busy_o,
    output logic                       done_o
);

    rc4_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0]   j_q, j_d;
    logic [DATA_W-1:0]   si_q, si_d;
    logic [DATA_W-1:0]   sj_q, sj_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                key_load;
    logic                key_step;
    logic [DATA_W-1:0]   key_byte;
    logic                wen;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic                done;
    logic                wait_last;

    rc4_key_sel #(
        .MAX_KEY_BYTES (MAX_KEY_BYTES)
    ) u_key_sel (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (key_load),
        .step_i     (key_step),
        .key_i      (secret_key_i),
        .key_len_i  (key_len_i),
        .key_byte_o (key_byte)
    );

    // The read address is held for RD_LAT+1 cycles; q_i is sampled on the
    // last of those edges, one cycle after it first becomes valid.
    assign wait_last = (wait_q == WAIT_W'(RD_LAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        si_d     = si_q;
        sj_d     = sj_q;
        wait_d   = wait_q;
        key_load = 1'b0;
        key_step = 1'b0;
        wen      = 1'b0;
        addr     = '0;
        wdata    = '0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    key_load = 1'b1;
                    i_d      = '0;
                    j_d      = '0;
                    wait_d   = '0;
                    state_d  = init_en_i ? ST_FILL : ST_RD_I;
                end
            end
            ST_FILL: begin
                wen   = 1'b1;
                addr  = i_q;
                wdata = i_q;
                // i wraps 255 -> 0 naturally, leaving it ready for the KSA.
                i_d   = i_q + ADDR_W'(1);
                if (i_q == ADDR_W'(SBOX_SIZE - 1)) begin
                    state_d = ST_RD_I;
                end
            end
            ST_RD_I: begin
                addr = i_q;
                if (wait_last) begin
                    si_d    = q_i;
                    wait_d  = '0;
                    state_d = ST_CALC_J;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            ST_CALC_J: begin
                j_d     = j_q + si_q + key_byte;
                state_d = ST_RD_J;
            end
            ST_RD_J: begin
                addr = j_q;
                if (wait_last) begin
                    sj_d    = q_i;
                    wait_d  = '0;
                    state_d = ST_WR_J;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            ST_WR_J: begin
                wen     = 1'b1;
                addr    = j_q;
                wdata   = si_q;
                state_d = ST_WR_I;
            end
            ST_WR_I: begin
                wen   = 1'b1;
                addr  = i_q;
                wdata = sj_q;
                if (i_q == ADDR_W'(SBOX_SIZE - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    i_d      = i_q + ADDR_W'(1);
                    key_step = 1'b1;
                    state_d  = ST_RD_I;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort kills the run in the same cycle: no write, no done pulse.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            wen      = 1'b0;
            key_step = 1'b0;
            done     = 1'b0;
        end
    end

    assign wen_o     = wen;
    assign address_o = addr;
    assign data_o    = wdata;
    assign done_o    = done;
    assign busy_o    = (state_q != ST_IDLE);

endmodule
`default_nettype wire
